// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: walks FETCH -> LATCH -> DECODE per instruction,
// folds an EXTEND prefix into the following word and tracks the bank selects.
module fetch_sequencer #(
  parameter logic [15:0] RESET_Z     = 16'd2048,
  parameter logic [15:0] EXTEND_WORD = 16'd6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        halt,
  input  logic        stall,
  input  logic [15:0] memResult,
  input  logic        loadBanks,
  input  logic [8:0]  bankIn,
  output logic [11:0] memAddress,
  output logic [2:0]  eBank,
  output logic [4:0]  fBank,
  output logic        superBank,
  output logic [15:0] regZ,
  output logic [15:0] instr,
  output logic [2:0]  opcode,
  output logic        extended,
  output logic        instrValid,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_LATCH, S_DECODE} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_z;
  logic [15:0] r_instr;
  logic [11:0] r_addr;
  logic        r_ext;
  logic [2:0]  r_ebank;
  logic [4:0]  r_fbank;
  logic        r_super;
  logic        w_is_prefix;
  logic        w_valid;
  logic        w_ext_set;
  logic        w_ext_clr;

  always_comb begin
    w_next      = r_state;
    w_valid     = 1'b0;
    w_ext_set   = 1'b0;
    w_ext_clr   = 1'b0;
    // A prefix seen while already extended is an ordinary instruction (no chaining).
    w_is_prefix = (r_instr == EXTEND_WORD) && !r_ext;
    case (r_state)
      S_IDLE:   if (start) w_next = S_FETCH;
      S_FETCH:  w_next = S_LATCH;
      S_LATCH:  w_next = S_DECODE;
      S_DECODE: begin
        if (w_is_prefix) begin
          w_ext_set = 1'b1;
          w_next    = S_FETCH;
        end else begin
          w_valid   = 1'b1;
          w_ext_clr = 1'b1;
          w_next    = halt ? S_IDLE : S_FETCH;
        end
      end
      default:  w_next = S_IDLE;
    endcase
    if (stall) begin
      w_next    = r_state;
      w_valid   = 1'b0;
      w_ext_set = 1'b0;
      w_ext_clr = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_z     <= RESET_Z;
      r_instr <= 16'd0;
      r_addr  <= 12'd0;
      r_ext   <= 1'b0;
      r_ebank <= 3'd0;
      r_fbank <= 5'd0;
      r_super <= 1'b0;
    end else if (!stall) begin
      if (r_state == S_FETCH) r_addr <= r_z[11:0];
      if (r_state == S_LATCH) begin
        r_instr <= memResult;
        r_z     <= r_z + 16'd1;
      end
      if (w_ext_set)      r_ext <= 1'b1;
      else if (w_ext_clr) r_ext <= 1'b0;
      if (loadBanks) begin
        r_super <= bankIn[8];
        r_fbank <= bankIn[7:3];
        r_ebank <= bankIn[2:0];
      end
    end
  end

  // The address is presented during FETCH itself, then held by r_addr.
  assign memAddress = (r_state == S_FETCH) ? r_z[11:0] : r_addr;
  assign eBank      = r_ebank;
  assign fBank      = r_fbank;
  assign superBank  = r_super;
  assign regZ       = r_z;
  assign instr      = r_instr;
  assign opcode     = r_instr[14:12];
  assign extended   = r_ext;
  assign instrValid = w_valid;
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: vector table of single/prefixed
// instructions plus hand-written stall, halt, bank and reset sequences.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, halt, stall, loadBanks;
  logic [15:0] memResult;
  logic [8:0]  bankIn;
  logic [11:0] memAddress;
  logic [2:0]  eBank;
  logic [4:0]  fBank;
  logic        superBank;
  logic [15:0] regZ, instr;
  logic [2:0]  opcode;
  logic        extended, instrValid, busy;

  logic [15:0] mem [0:63];
  assign memResult = mem[memAddress[5:0]];

  fetch_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .halt(halt), .stall(stall),
    .memResult(memResult), .loadBanks(loadBanks), .bankIn(bankIn),
    .memAddress(memAddress), .eBank(eBank), .fBank(fBank), .superBank(superBank),
    .regZ(regZ), .instr(instr), .opcode(opcode), .extended(extended),
    .instrValid(instrValid), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] w0;
    logic [15:0] w1;
    logic        pair;
    logic [15:0] e_instr;
    logic [2:0]  e_op;
    logic        e_ext;
    int          e_lat;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int n);
    n = 1;
    while (!instrValid && n < 12) begin
      tick();
      n++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] exp_z;
    logic [15:0] tmp;
    logic [15:0] old_instr;
    int n;

    vecs[0] = '{16'h1234, 16'h0000, 1'b0, 16'h1234, 3'd1, 1'b0, 3};
    vecs[1] = '{16'h0006, 16'h5003, 1'b1, 16'h5003, 3'd5, 1'b1, 6};
    vecs[2] = '{16'h0006, 16'h0006, 1'b1, 16'h0006, 3'd0, 1'b1, 6};
    vecs[3] = '{16'h7FFF, 16'h0000, 1'b0, 16'h7FFF, 3'd7, 1'b0, 3};
    vecs[4] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 3'd0, 1'b0, 3};

    for (int i = 0; i < 64; i++) mem[i] = 16'h0;
    reset = 1'b1; start = 1'b0; halt = 1'b0; stall = 1'b0;
    loadBanks = 1'b0; bankIn = 9'd0;
    #2;
    chk("rst_regZ", regZ, 16'd2048);
    chk("rst_addr", memAddress, 12'd0);
    chk("rst_instr", instr, 16'd0);
    chk("rst_ext", extended, 1'b0);
    chk("rst_valid", instrValid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_banks", {superBank, fBank, eBank}, 9'd0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    chk("idle_busy", busy, 1'b0);
    exp_z = 16'd2048;

    for (int i = 0; i < 5; i++) begin
      mem[exp_z[5:0]] = vecs[i].w0;
      tmp = exp_z + 16'd1;
      mem[tmp[5:0]] = vecs[i].w1;
      halt = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      chk($sformatf("v%0d_fetch_addr", i), memAddress, exp_z[11:0]);
      chk($sformatf("v%0d_busy", i), busy, 1'b1);
      wait_valid(n);
      exp_z = exp_z + (vecs[i].pair ? 16'd2 : 16'd1);
      chk($sformatf("v%0d_latency", i), n, vecs[i].e_lat);
      chk($sformatf("v%0d_instr", i), instr, vecs[i].e_instr);
      chk($sformatf("v%0d_opcode", i), opcode, vecs[i].e_op);
      chk($sformatf("v%0d_ext", i), extended, vecs[i].e_ext);
      chk($sformatf("v%0d_regZ", i), regZ, exp_z);
      tick();
      tmp = exp_z - 16'd1;
      chk($sformatf("v%0d_idle", i), busy, 1'b0);
      chk($sformatf("v%0d_valid_off", i), instrValid, 1'b0);
      chk($sformatf("v%0d_ext_clr", i), extended, 1'b0);
      chk($sformatf("v%0d_addr_hold", i), memAddress, tmp[11:0]);
    end

    // back-to-back run with halt low, then halt on the second instruction
    mem[exp_z[5:0]] = 16'h3001;
    tmp = exp_z + 16'd1;
    mem[tmp[5:0]] = 16'h4002;
    halt = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    wait_valid(n);
    chk("run1_instr", instr, 16'h3001);
    tick();
    chk("run_continue", busy, 1'b1);
    chk("run_next_addr", memAddress, tmp[11:0]);
    halt = 1'b1;
    wait_valid(n);
    chk("run2_lat", n, 3);
    chk("run2_instr", instr, 16'h4002);
    exp_z = exp_z + 16'd2;
    chk("run2_regZ", regZ, exp_z);
    tick();
    chk("run2_idle", busy, 1'b0);

    // stall for two cycles while in LATCH, then stall again in DECODE
    mem[exp_z[5:0]] = 16'h2222;
    old_instr = instr;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    stall = 1'b1;
    tick();
    chk("stall1_instr", instr, old_instr);
    chk("stall1_regZ", regZ, exp_z);
    chk("stall1_valid", instrValid, 1'b0);
    tick();
    chk("stall2_instr", instr, old_instr);
    chk("stall2_regZ", regZ, exp_z);
    chk("stall2_valid", instrValid, 1'b0);
    stall = 1'b0;
    tick();
    exp_z = exp_z + 16'd1;
    chk("stall_delayed_valid", instrValid, 1'b1);
    chk("stall_instr", instr, 16'h2222);
    chk("stall_regZ", regZ, exp_z);
    stall = 1'b1;
    #1;
    chk("stall_dec_valid", instrValid, 1'b0);
    tick();
    chk("stall_dec_busy", busy, 1'b1);
    chk("stall_dec_valid2", instrValid, 1'b0);
    stall = 1'b0;
    #1;
    chk("stall_release_valid", instrValid, 1'b1);
    tick();
    chk("stall_release_idle", busy, 1'b0);

    // bank load, and a load blocked by stall
    loadBanks = 1'b1; bankIn = 9'b1_10101_011;
    tick();
    loadBanks = 1'b0;
    chk("bank_super", superBank, 1'b1);
    chk("bank_f", fBank, 5'd21);
    chk("bank_e", eBank, 3'd3);
    loadBanks = 1'b1; bankIn = 9'd0; stall = 1'b1;
    tick();
    loadBanks = 1'b0; stall = 1'b0;
    chk("bank_stalled", {superBank, fBank, eBank}, 9'b1_10101_011);

    // reset in LATCH aborts the instruction
    mem[exp_z[5:0]] = 16'h6666;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    chk("rstL_busy", busy, 1'b0);
    chk("rstL_regZ", regZ, 16'd2048);
    chk("rstL_valid", instrValid, 1'b0);
    chk("rstL_banks", {superBank, fBank, eBank}, 9'd0);
    tick();
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (instrValid || busy) n++;
    end
    chk("rstL_no_resume", n, 0);
    chk("rstL_instr", instr, 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter RESET_Z, default 16'd2048 (octal 04000), meaning the Z value loaded at reset.
REQ-002 SHALL have parameter EXTEND_WORD, default 16'd6, meaning the instruction word treated as the EXTEND prefix.
REQ-003 SHALL have one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port clk  input  1  system clock, rising-edge active.
REQ-005 SHALL have port reset  input  1  asynchronous active-high reset.
REQ-006 SHALL have port start  input  1  begin fetching from IDLE.
REQ-007 SHALL have port halt  input  1  return to IDLE after the current instruction.
REQ-008 SHALL have port stall  input  1  freeze all state and outputs for the cycle.
REQ-009 SHALL have port memResult  input  16  read data returned by the memory stage.
REQ-010 SHALL have port loadBanks  input  1  load the bank registers this cycle.
REQ-011 SHALL have port bankIn  input  9  {superBank, fBank[4:0], eBank[2:0]} load value.
REQ-012 SHALL have port memAddress  output  12  fetch address to memory.
REQ-013 SHALL have ports eBank (output, 3), fBank (output, 5) and superBank (output, 1), meaning registered bank selects to memory.
REQ-014 SHALL have port regZ  output  16  program counter.
REQ-015 SHALL have port instr  output  16  latched instruction word.
REQ-016 SHALL have port opcode  output  3  instr[14:12].
REQ-017 SHALL have port extended  output  1  current instr was preceded by EXTEND.
REQ-018 SHALL have port instrValid  output  1  one-cycle strobe, instr is decoded and valid.
REQ-019 SHALL have port busy  output  1  high in any state except IDLE.

Function
REQ-020 SHALL implement states IDLE, FETCH, LATCH, DECODE.
REQ-021 IDLE -> FETCH on start=1; otherwise IDLE.
REQ-022 In FETCH, memAddress SHALL be set to regZ[11:0]; the next state is LATCH.
REQ-023 In LATCH, instr SHALL capture memResult, and regZ SHALL become regZ+1 (16-bit, 16'hFFFF wraps to 0); the next state is DECODE.
REQ-024 In DECODE, if instr==EXTEND_WORD and extended==0: extended is set to 1, instrValid stays 0, and the next state is FETCH.
REQ-025 In DECODE, if instr==EXTEND_WORD while extended==1: it is treated as an ordinary instruction with extended=1; EXTEND SHALL NOT chain.
REQ-026 In DECODE, otherwise: instrValid=1 for exactly this cycle; the next state is IDLE if halt=1, else FETCH.
REQ-027 extended SHALL clear on the transition out of a DECODE that asserted instrValid.
REQ-028 memAddress and instr SHALL hold their values outside the state that updates them.
REQ-029 Latency SHALL be 3 cycles per instruction (FETCH, LATCH, DECODE) and 6 cycles for an EXTEND-prefixed pair.
REQ-030 stall=1 SHALL hold state, regZ, instr, extended and the banks; instrValid SHALL be forced to 0 while stall=1, and the strobe SHALL fire once stall deasserts.
REQ-031 loadBanks=1 (and stall=0) SHALL update the banks at the clock edge in any state; the new value SHALL be visible on memory outputs from the next cycle.
REQ-032 halt SHALL be sampled only in DECODE; start SHALL be ignored outside IDLE.
REQ-033 start and halt both high in IDLE: the block SHALL enter FETCH.

Reset
REQ-034 While reset=1, asynchronously: state=IDLE, regZ=RESET_Z, memAddress=0, instr=0, extended=0, instrValid=0, busy=0, eBank=0, fBank=0, superBank=0.
REQ-035 Reset asserted mid-instruction SHALL abort it with no instrValid strobe; fetch resumes only on a new start.

Verification
REQ-036 Reset, start pulse, memResult=16'h1234 -> memAddress=12'd2048 in FETCH; instrValid=1 on 3rd cycle; instr=16'h1234, opcode=3'd1, regZ=16'd2049.
REQ-037 memResult=16'd6 then 16'h5003 -> extended=1, single instrValid on cycle 6, instr=16'h5003, opcode=3'd5, regZ advanced by 2.
REQ-038 stall=1 for 2 cycles during LATCH -> instr and regZ unchanged during stall; instrValid delayed exactly 2 cycles.
REQ-039 halt=1 during DECODE -> instrValid=1 that cycle, then busy=0, and memAddress holds its last value.
REQ-040 loadBanks=1, bankIn=9'b1_10101_011 -> next cycle superBank=1, fBank=5'd21, eBank=3'd3.
REQ-041 reset asserted in LATCH -> immediate IDLE, regZ=16'd2048, no instrValid strobe.
